// File: rtl/id_operand_scoreboard.sv
// id_operand_scoreboard: decode-stage operand hazard unit.
// Holds one decoded instruction. Tracks in-flight writers in a PIPE_DEPTH-entry
// shift-register scoreboard. Resolves rs1/rs2 from the youngest forwardable
// stage, or from the register file.
// Optional feature: define ID_PERF_CNT_EN to add the stall and flush perf counters.

// Resolves one source operand against the scoreboard.
module id_src_resolve #(
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 2
)(
  input  logic [4:0]                 addr,
  input  logic                       used,
  input  logic [XLEN-1:0]            rf_data,
  input  logic [PIPE_DEPTH-1:0]      sb_v,
  input  logic [PIPE_DEPTH-1:0][4:0] sb_rd,
  input  logic [PIPE_DEPTH-1:0]      sb_wr,
  input  logic [PIPE_DEPTH-1:0]      sb_ld,
  input  logic [PIPE_DEPTH*XLEN-1:0] stage_result,
  output logic [XLEN-1:0]            op,
  output logic                       hz
);
  logic found, fwd;

  // Scan from the oldest slot to the youngest so the lowest matching slot wins.
  always_comb begin
    found = 1'b0;
    fwd   = 1'b0;
    op    = rf_data;
    for (int k = PIPE_DEPTH-1; k >= 0; k--) begin
      if (sb_v[k] && sb_wr[k] && (sb_rd[k] == addr)) begin
        found = 1'b1;
        fwd   = !sb_ld[k] || (k >= LOAD_LAT-1);
        op    = stage_result[k*XLEN +: XLEN];
      end
    end
    if (addr == 5'd0) op = '0;
    hz = used && (addr != 5'd0) && found && !fwd;
  end
endmodule

module id_operand_scoreboard #(
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 2
)(
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       if_valid_i,
  output logic                       if_ready_o,
  input  logic [4:0]                 if_rs1_i,
  input  logic [4:0]                 if_rs2_i,
  input  logic                       if_rs1_used_i,
  input  logic                       if_rs2_used_i,
  input  logic [4:0]                 if_rd_i,
  input  logic                       if_rd_wr_en_i,
  input  logic                       if_is_load_i,
  input  logic [XLEN-1:0]            rf_rs1_data_i,
  input  logic [XLEN-1:0]            rf_rs2_data_i,
  input  logic [PIPE_DEPTH*XLEN-1:0] stage_result_i,
  input  logic                       ex_ready_i,
  input  logic                       flush_i,
  output logic                       id_valid_o,
  output logic [XLEN-1:0]            id_rs1_data_o,
  output logic [XLEN-1:0]            id_rs2_data_o,
  output logic [4:0]                 id_rd_o,
  output logic                       id_stall_o
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]                perf_stall_cnt_o,
  output logic [31:0]                perf_flush_cnt_o
`endif
);
  // Held decode instruction.
  logic       hold_valid;
  logic [1:0][4:0] h_src;
  logic [1:0] h_used;
  logic [4:0] h_rd;
  logic       h_wr, h_ld;

  // Scoreboard: slot 0 = EX, slot PIPE_DEPTH-1 = WB.
  logic [PIPE_DEPTH-1:0]      sb_v, sb_wr, sb_ld;
  logic [PIPE_DEPTH-1:0][4:0] sb_rd;

  logic [1:0][XLEN-1:0] src_rf, src_op;
  logic [1:0]           src_hz;
  logic                 hazard, issue;

  assign src_rf = {rf_rs2_data_i, rf_rs1_data_i};

  for (genvar s = 0; s < 2; s++) begin : g_src
    id_src_resolve #(.XLEN(XLEN), .PIPE_DEPTH(PIPE_DEPTH), .LOAD_LAT(LOAD_LAT)) u_res (
      .addr(h_src[s]), .used(h_used[s]), .rf_data(src_rf[s]),
      .sb_v(sb_v), .sb_rd(sb_rd), .sb_wr(sb_wr), .sb_ld(sb_ld),
      .stage_result(stage_result_i), .op(src_op[s]), .hz(src_hz[s])
    );
  end

  assign hazard        = |src_hz;
  assign id_stall_o    = hold_valid && hazard;
  assign id_valid_o    = hold_valid && !hazard && !flush_i;
  assign issue         = id_valid_o && ex_ready_i;
  assign if_ready_o    = !hold_valid || issue || flush_i;
  assign id_rs1_data_o = src_op[0];
  assign id_rs2_data_o = src_op[1];
  assign id_rd_o       = h_rd;

  // Hold register and scoreboard advance. Both freeze while EX is not ready;
  // a flush still empties the hold slot but pushes no entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_valid <= 1'b0;
      h_src      <= '0;
      h_used     <= '0;
      h_rd       <= '0;
      h_wr       <= 1'b0;
      h_ld       <= 1'b0;
      sb_v       <= '0;
      sb_rd      <= '0;
      sb_wr      <= '0;
      sb_ld      <= '0;
    end else begin
      if (ex_ready_i) begin
        for (int k = PIPE_DEPTH-1; k >= 1; k--) begin
          sb_v[k]  <= sb_v[k-1];
          sb_rd[k] <= sb_rd[k-1];
          sb_wr[k] <= sb_wr[k-1];
          sb_ld[k] <= sb_ld[k-1];
        end
        sb_v[0]  <= issue;
        sb_rd[0] <= h_rd;
        sb_wr[0] <= h_wr;
        sb_ld[0] <= h_ld;
      end
      if (if_valid_i && if_ready_o) begin
        hold_valid <= 1'b1;
        h_src      <= {if_rs2_i, if_rs1_i};
        h_used     <= {if_rs2_used_i, if_rs1_used_i};
        h_rd       <= if_rd_i;
        h_wr       <= if_rd_wr_en_i;
        h_ld       <= if_is_load_i;
      end else if (issue || flush_i) begin
        hold_valid <= 1'b0;
      end
    end
  end

`ifdef ID_PERF_CNT_EN
  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (id_stall_o)            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (flush_i && hold_valid) perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
    end
  end
`else
  // Perf counters are not built.
`endif
endmodule

// File: tb/tb_id_operand_scoreboard.sv
// Self-checking bench for id_operand_scoreboard.
// Directed hazard scenarios are followed by randomized traffic.
// The reference model keeps in-flight writers as (rd, age) records.
module tb_id_operand_scoreboard;
  localparam int XLEN = 32, PD = 3, LL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, if_valid, if_ready, u1, u2, wr, ld, ex_ready, flush, id_valid, id_stall;
  logic [4:0] rs1, rs2, rd, id_rd;
  logic [XLEN-1:0] rf1, rf2, id_rs1, id_rs2;
  logic [PD*XLEN-1:0] sr;
  int checks = 0, errors = 0;

  id_operand_scoreboard #(.XLEN(XLEN), .PIPE_DEPTH(PD), .LOAD_LAT(LL)) dut (
    .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_ready_o(if_ready),
    .if_rs1_i(rs1), .if_rs2_i(rs2), .if_rs1_used_i(u1), .if_rs2_used_i(u2),
    .if_rd_i(rd), .if_rd_wr_en_i(wr), .if_is_load_i(ld),
    .rf_rs1_data_i(rf1), .rf_rs2_data_i(rf2), .stage_result_i(sr),
    .ex_ready_i(ex_ready), .flush_i(flush), .id_valid_o(id_valid),
    .id_rs1_data_o(id_rs1), .id_rs2_data_o(id_rs2), .id_rd_o(id_rd), .id_stall_o(id_stall)
  );

  typedef struct packed {logic [4:0] rs1, rs2, rd; logic u1, u2, wr, ld;} instr_t;
  typedef struct packed {logic [4:0] rd; logic wr, ld; int age;} fly_t;
  instr_t held;
  logic   held_v;
  fly_t   fly[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // The youngest in-flight writer of the register wins. A load is usable only
  // once its age reaches LL-1.
  function automatic void resolve(input logic [4:0] a, input logic used,
                                  input logic [XLEN-1:0] rf,
                                  output logic [XLEN-1:0] op, output logic hz);
    int best = -1;
    hz = 1'b0;
    op = rf;
    if (a == 5'd0) begin op = '0; return; end
    foreach (fly[i])
      if (fly[i].wr && fly[i].rd == a && (best < 0 || fly[i].age < fly[best].age)) best = i;
    if (best >= 0) begin
      if (!fly[best].ld || fly[best].age >= LL-1) op = sr[fly[best].age*XLEN +: XLEN];
      else hz = used;
    end
  endfunction

  // One clock: check the outputs against the model, then advance the model.
  task automatic cyc();
    logic [XLEN-1:0] e1, e2;
    logic h1, h2, hz, ev, er;
    resolve(held.rs1, held.u1, rf1, e1, h1);
    resolve(held.rs2, held.u2, rf2, e2, h2);
    hz = held_v && (h1 || h2);
    ev = held_v && !hz && !flush;
    er = !held_v || (ev && ex_ready) || flush;
    #1;
    chk("if_ready", if_ready, er);
    chk("id_valid", id_valid, ev);
    chk("id_stall", id_stall, hz);
    if (held_v) chk("id_rd", id_rd, held.rd);
    if (ev && held.u1) chk("id_rs1", id_rs1, e1);
    if (ev && held.u2) chk("id_rs2", id_rs2, e2);
    @(posedge clk);
    if (rst) begin
      held_v = 1'b0; held = '0; fly.delete();
    end else begin
      if (ex_ready) begin
        foreach (fly[i]) fly[i].age++;
        for (int i = fly.size()-1; i >= 0; i--) if (fly[i].age >= PD) fly.delete(i);
        if (ev) fly.push_back('{rd: held.rd, wr: held.wr, ld: held.ld, age: 0});
      end
      if (if_valid && er) begin
        held = '{rs1: rs1, rs2: rs2, rd: rd, u1: u1, u2: u2, wr: wr, ld: ld};
        held_v = 1'b1;
      end else if ((ev && ex_ready) || flush) held_v = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic set_if(input logic v, input logic [4:0] a1, input logic b1,
                        input logic [4:0] a2, input logic b2,
                        input logic [4:0] d, input logic w, input logic l);
    if_valid = v; rs1 = a1; u1 = b1; rs2 = a2; u2 = b2; rd = d; wr = w; ld = l;
  endtask

  task automatic chk_reset_outs();
    #1;
    chk("rst_if_ready", if_ready, 1'b1);
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_stall", id_stall, 1'b0);
    chk("rst_rs1", id_rs1, 32'd0);
    chk("rst_rs2", id_rs2, 32'd0);
    chk("rst_rd", id_rd, 5'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    set_if(0, 0, 0, 0, 0, 0, 0, 0);
    rf1 = 32'h1111; rf2 = 32'h2222; sr = '0;
    held = '0; held_v = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outs();

    // ALU chain: forward slot 0 without a stall.
    set_if(1, 0, 0, 0, 0, 5, 1, 0); cyc();
    set_if(1, 5, 1, 0, 0, 8, 1, 0); cyc();
    set_if(0, 0, 0, 0, 0, 0, 0, 0); sr[0 +: XLEN] = 32'h10;
    #1; chk("t1_rs1", id_rs1, 32'h10); chk("t1_stall", id_stall, 1'b0);
    cyc();

    // Load-use: one stall cycle, then slot 1 data.
    set_if(1, 0, 0, 0, 0, 6, 1, 1); cyc();
    set_if(1, 0, 0, 6, 1, 9, 1, 0); cyc();
    set_if(0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("t2_stall1", id_stall, 1'b1);
    cyc();
    sr[XLEN +: XLEN] = 32'h66;
    #1; chk("t2_stall2", id_stall, 1'b0); chk("t2_rs2", id_rs2, 32'h66);
    cyc();

    // A writer of x0 never creates a hazard.
    set_if(1, 0, 0, 0, 0, 0, 1, 1); cyc();
    set_if(1, 0, 1, 0, 0, 3, 1, 0); cyc();
    set_if(0, 0, 0, 0, 0, 0, 0, 0); sr = {32'h5, 32'h6, 32'h7};
    #1; chk("t3_rs1", id_rs1, 32'd0); chk("t3_stall", id_stall, 1'b0);
    cyc();

    // The youngest writer wins.
    set_if(1, 0, 0, 0, 0, 7, 1, 0); cyc();
    set_if(1, 0, 0, 0, 0, 0, 0, 0); cyc();
    set_if(1, 0, 0, 0, 0, 7, 1, 0); cyc();
    set_if(1, 7, 1, 0, 0, 4, 1, 0); cyc();
    set_if(0, 0, 0, 0, 0, 0, 0, 0); sr = {32'hAA, 32'h0, 32'hBB};
    #1; chk("t4_rs1", id_rs1, 32'hBB);
    cyc();

    // A back-pressure stall holds the hazard until EX frees up.
    set_if(1, 0, 0, 0, 0, 9, 1, 1); cyc();
    set_if(1, 9, 1, 0, 0, 2, 1, 0); cyc();
    set_if(0, 0, 0, 0, 0, 0, 0, 0); ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("t5_frozen_stall", id_stall, 1'b1);
      cyc();
    end
    ex_ready = 1'b1; cyc();
    sr[XLEN +: XLEN] = 32'h99;
    #1; chk("t5_rs1", id_rs1, 32'h99); chk("t5_valid", id_valid, 1'b1);
    cyc();

    // A flush during a stall drops the instruction; reset mid-stream clears all.
    set_if(1, 0, 0, 0, 0, 10, 1, 1); cyc();
    set_if(1, 10, 1, 0, 0, 11, 1, 0); cyc();
    set_if(0, 0, 0, 0, 0, 0, 0, 0); flush = 1'b1;
    #1; chk("t6_valid", id_valid, 1'b0); chk("t6_ready", if_ready, 1'b1);
    cyc();
    flush = 1'b0; cyc();
    set_if(1, 0, 0, 0, 0, 12, 1, 1); cyc();
    set_if(1, 12, 1, 12, 1, 13, 1, 0); cyc();
    rst = 1'b1; cyc();
    rst = 1'b0; set_if(0, 0, 0, 0, 0, 0, 0, 0);
    chk_reset_outs();
    cyc();

    // Randomized traffic on a small register set, so hazards are common.
    for (int n = 0; n < 600; n++) begin
      set_if($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
             1'($urandom), $urandom_range(0, 2) == 0);
      ex_ready = $urandom_range(0, 4) != 0;
      flush    = $urandom_range(0, 9) == 0;
      rst      = $urandom_range(0, 63) == 0;
      rf1 = $urandom; rf2 = $urandom;
      sr  = {$urandom, $urandom, $urandom};
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
